// File: rtl/tile_game_sequencer.sv
// Piano-tiles game controller: game FSM, tile step divider, PS/2 key judging, score and lives.
// Optional build macro TILE_LIVES_EN gives three lives per game; without it one miss ends the game.
module tile_game_sequencer #(
  parameter int STEP_CYCLES = 22_222_223,
  parameter int SONG_LEN    = 74,
  parameter int COUNT_STEPS = 3,
  parameter int SCORE_W     = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         received_data,
  input  logic               received_data_en,
  input  logic [7:0]         song_key,
  output logic [6:0]         song_addr,
  output logic               step,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               hit
);

  localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int CNT_W = $clog2(COUNT_STEPS + 1);

  localparam logic [7:0] K_SPACE = 8'h29, K_A = 8'h1c, K_S = 8'h1b, K_D = 8'h23, K_F = 8'h2b;
  localparam logic [7:0] K_EMPTY = 8'h05, K_BREAK = 8'hf0, K_EXT = 8'he0;

`ifdef TILE_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'd3;
`else
  localparam logic [1:0] LIVES_INIT = 2'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_COUNTDOWN = 3'd1, S_PLAY = 3'd2, S_GAMEOVER = 3'd3, S_WIN = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               break_pending, break_pending_n;
  logic               step_n, hit_n, hit_mid, miss;
  logic [6:0]         addr_n;
  logic [SCORE_W-1:0] score_n;
  logic [1:0]         lives_n;
  logic               make, lane_key, space_key, run, run_n, last_tile, last_count;

  assign state      = state_q;
  assign last_tile  = (song_addr == 7'(SONG_LEN - 1));
  assign last_count = (cnt == CNT_W'(COUNT_STEPS - 1));

  // Byte after a BREAK is the released key and is discarded; EXT prefixes never disturb this.
  always_comb begin
    make            = received_data_en && (received_data != K_EXT) &&
                      (received_data != K_BREAK) && !break_pending;
    break_pending_n = break_pending;
    if (received_data_en && (received_data != K_EXT))
      break_pending_n = break_pending ? 1'b0 : (received_data == K_BREAK);
    lane_key  = make && ((received_data == K_A) || (received_data == K_S) ||
                         (received_data == K_D) || (received_data == K_F));
    space_key = make && (received_data == K_SPACE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      div           <= '0;
      cnt           <= '0;
      break_pending <= 1'b0;
      step          <= 1'b0;
      hit           <= 1'b0;
      song_addr     <= '0;
      score         <= '0;
      lives         <= LIVES_INIT;
    end else begin
      state_q       <= state_n;
      div           <= div_n;
      cnt           <= cnt_n;
      break_pending <= break_pending_n;
      step          <= step_n;
      hit           <= hit_n;
      song_addr     <= addr_n;
      score         <= score_n;
      lives         <= lives_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:      if (space_key) state_n = S_COUNTDOWN;
      S_COUNTDOWN: if (step && last_count) state_n = S_PLAY;
      S_PLAY: begin
        if (miss && (lives == 2'd1)) state_n = S_GAMEOVER;
        else if (step && last_tile)  state_n = S_WIN;
      end
      S_GAMEOVER, S_WIN: if (space_key) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_comb begin
    hit_mid = hit;
    miss    = 1'b0;
    hit_n   = hit;
    addr_n  = song_addr;
    score_n = score;
    lives_n = lives;
    cnt_n   = cnt;
    case (state_q)
      S_IDLE: if (space_key) begin
        score_n = '0;
        lives_n = LIVES_INIT;
        addr_n  = '0;
        cnt_n   = '0;
        hit_n   = 1'b0;
      end
      S_COUNTDOWN: if (step) begin
        if (last_count) begin
          addr_n = '0;
          hit_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PLAY: begin
        // Key is judged first so a hit landing on the step tick saves the tile.
        if (lane_key) begin
          if ((received_data == song_key) && (song_key != K_EMPTY) && !hit) begin
            hit_mid = 1'b1;
            if (score != '1) score_n = score + SCORE_W'(1);
          end else begin
            miss = 1'b1;
          end
        end
        hit_n = hit_mid;
        if (step) begin
          if ((song_key != K_EMPTY) && !hit_mid) miss = 1'b1;
          hit_n = 1'b0;
          if (!last_tile) addr_n = song_addr + 7'd1;
        end
        if (miss) lives_n = lives - 2'd1;
      end
      S_GAMEOVER, S_WIN: if (space_key) begin
        score_n = '0;
        addr_n  = '0;
        hit_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // Divider and its registered step pulse advance together, so step marks count == STEP_CYCLES-1.
  always_comb begin
    run    = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
    run_n  = (state_n == S_COUNTDOWN) || (state_n == S_PLAY);
    div_n  = '0;
    if (run && run_n && (div != DIV_W'(STEP_CYCLES - 1))) div_n = div + DIV_W'(1);
    step_n = run_n && (div_n == DIV_W'(STEP_CYCLES - 1));
  end

endmodule

// File: tb/tb_tile_game_sequencer.sv
// Self-checking bench for tile_game_sequencer: short song, fast step, scoreboard of expected outputs.
// Expectations follow TILE_LIVES_EN when the macro is defined for the build.
module tb_tile_game_sequencer;
  localparam int STEP = 8;
  localparam int LEN  = 4;
  localparam int CNT  = 3;
  localparam int SW   = 10;
`ifdef TILE_LIVES_EN
  localparam int LIVES_INIT = 3;
`else
  localparam int LIVES_INIT = 1;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    received_data = 8'h00;
  logic          received_data_en = 1'b0;
  logic [7:0]    song_key;
  logic [6:0]    song_addr;
  logic          step;
  logic [2:0]    state;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic          hit;

  tile_game_sequencer #(.STEP_CYCLES(STEP), .SONG_LEN(LEN), .COUNT_STEPS(CNT), .SCORE_W(SW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data),
    .received_data_en(received_data_en), .song_key(song_key), .song_addr(song_addr),
    .step(step), .state(state), .score(score), .lives(lives), .hit(hit)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Song: A, EMPTY, S, D
  always_comb begin
    case (song_addr)
      7'd0:    song_key = 8'h1c;
      7'd2:    song_key = 8'h1b;
      7'd3:    song_key = 8'h23;
      default: song_key = 8'h05;
    endcase
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    int    st;
    int    sc;
    int    lv;
    int    ad;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] key;
    bit         press;
    int         sc_key;
    int         sc_step;
    int         ad_step;
    int         st_step;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic push_exp(input string n, input int st, input int sc, input int lv, input int ad);
    exp_t e;
    e.name = n; e.st = st; e.sc = sc; e.lv = lv; e.ad = ad;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.name, ".state"}, 32'(state), e.st);
      chk({e.name, ".score"}, 32'(score), e.sc);
      chk({e.name, ".lives"}, 32'(lives), e.lv);
      if (e.ad >= 0) chk({e.name, ".addr"}, 32'(song_addr), e.ad);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    while (step !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (step !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got no step after %0d cycles", n);
    end
  endtask

  task automatic start_game();
    int n;
    send(8'h29);
    for (int i = 0; i < CNT; i++) begin
      wait_step(n);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{8'h1c, 1'b1, 1, 1, 1, 2};
    vecs[1] = '{8'h00, 1'b0, 1, 1, 2, 2};
    vecs[2] = '{8'h1b, 1'b1, 2, 2, 3, 2};
    vecs[3] = '{8'h23, 1'b1, 3, 3, 3, 4};

    // Reset and countdown timing
    repeat (2) tick();
    push_exp("reset", 0, 0, LIVES_INIT, 0);
    pop_check();
    chk("reset.step", 32'(step), 0);
    chk("reset.hit", 32'(hit), 0);
    reset = 1'b1;
    tick();
    chk("idle_hold.state", 32'(state), 0);
    send(8'h29);
    push_exp("space", 1, 0, LIVES_INIT, 0);
    pop_check();
    for (int i = 0; i < CNT; i++) begin
      wait_step(n);
      chk($sformatf("countdown%0d.gap", i), 32'(n), STEP - 1);
      chk($sformatf("countdown%0d.state", i), 32'(state), 1);
      tick();
      chk($sformatf("countdown%0d.step_len", i), 32'(step), 0);
    end
    push_exp("play_entry", 2, 0, LIVES_INIT, 0);
    pop_check();

    // Full song, table driven
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].press) begin
        push_exp($sformatf("vec%0d.key", i), 2, vecs[i].sc_key, LIVES_INIT, i);
        send(vecs[i].key);
        pop_check();
        chk($sformatf("vec%0d.hit", i), 32'(hit), 1);
      end
      push_exp($sformatf("vec%0d.step", i), vecs[i].st_step, vecs[i].sc_step, LIVES_INIT,
               vecs[i].ad_step);
      wait_step(n);
      tick();
      pop_check();
    end
    repeat (3) tick();
    chk("win.step", 32'(step), 0);
    push_exp("win_space", 0, 0, LIVES_INIT, 0);
    send(8'h29);
    pop_check();

    // Key strobed in the exact step cycle on tile A, then reset mid-play
    start_game();
    wait_step(n);
    push_exp("key_on_step", 2, 1, LIVES_INIT, 1);
    received_data    = 8'h1c;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    pop_check();
    chk("key_on_step.hit", 32'(hit), 0);
    push_exp("empty_tile", 2, 1, LIVES_INIT, 2);
    wait_step(n);
    tick();
    pop_check();
    push_exp("hit_s", 2, 2, LIVES_INIT, 2);
    send(8'h1b);
    pop_check();
    reset = 1'b0;
    push_exp("mid_reset", 0, 0, LIVES_INIT, 0);
    tick();
    pop_check();
    chk("mid_reset.step", 32'(step), 0);
    chk("mid_reset.hit", 32'(hit), 0);
    reset = 1'b1;
    tick();

    // Released key is discarded (EXT between BREAK and code); tile A then missed
    start_game();
    send(8'hf0);
    send(8'he0);
    send(8'h1c);
    push_exp("break_discard", 2, 0, LIVES_INIT, 0);
    pop_check();
    chk("break_discard.hit", 32'(hit), 0);
    wait_step(n);
    tick();
    if (LIVES_INIT > 1) begin
      push_exp("step_miss", 2, 0, LIVES_INIT - 1, 1);
      pop_check();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
    end else begin
      push_exp("step_miss", 3, 0, 0, -1);
      pop_check();
      push_exp("gameover_space", 0, 0, 0, 0);
      send(8'h29);
      pop_check();
    end

    // Wrong presses on an EMPTY tile drain lives to GAMEOVER
    start_game();
    send(8'h1c);
    wait_step(n);
    tick();
    for (int i = 0; i < LIVES_INIT; i++) begin
      push_exp($sformatf("empty_press%0d", i), (i == LIVES_INIT - 1) ? 3 : 2, 1,
               LIVES_INIT - 1 - i, 1);
      send(8'h23);
      pop_check();
    end
    repeat (STEP + 2) tick();
    chk("gameover.step", 32'(step), 0);
    push_exp("gameover_hold", 3, 1, 0, 1);
    pop_check();
    push_exp("gameover_space", 0, 0, 0, 0);
    send(8'h29);
    pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
